// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// mips_ctrl_pkg: shared encodings and control-word layout for the multicycle MIPS controller.
// Rev 1.0
package mips_ctrl_pkg;

   localparam logic [5:0] OP_R    = 6'd0,
                          OP_J    = 6'd2,
                          OP_JAL  = 6'd3,
                          OP_BNE  = 6'd5,
                          OP_XORI = 6'd14,
                          OP_LW   = 6'd35,
                          OP_SW   = 6'd43;

   localparam logic [5:0] FN_JR  = 6'd8,
                          FN_ADD = 6'd32,
                          FN_SUB = 6'd34,
                          FN_SLT = 6'd42;

   localparam logic [3:0] ALU_ADD = 4'd2,
                          ALU_SUB = 4'd6,
                          ALU_SLT = 4'd7,
                          ALU_XOR = 4'd10;

   localparam logic [3:0] S_IDLE   = 4'd0,
                          S_FETCH  = 4'd1,
                          S_DECODE = 4'd2,
                          S_MEMADR = 4'd3,
                          S_MEMRD  = 4'd4,
                          S_MEMWB  = 4'd5,
                          S_MEMWR  = 4'd6,
                          S_EXEC_R = 4'd7,
                          S_RWB    = 4'd8,
                          S_EXEC_I = 4'd9,
                          S_IWB    = 4'd10,
                          S_BRANCH = 4'd11,
                          S_JUMP   = 4'd12,
                          S_TRAP   = 4'd13;

   localparam logic [1:0] PC_SRC_PC4 = 2'd0,
                          PC_SRC_BR  = 2'd1,
                          PC_SRC_JMP = 2'd2,
                          PC_SRC_RS  = 2'd3;

   localparam logic       SRCA_PC = 1'b0,
                          SRCA_RS = 1'b1;

   localparam logic [1:0] SRCB_RT   = 2'd0,
                          SRCB_FOUR = 2'd1,
                          SRCB_IMM  = 2'd2,
                          SRCB_BOFF = 2'd3;

   localparam logic [1:0] DST_RT = 2'd0,
                          DST_RD = 2'd1,
                          DST_RA = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0,
                          WB_MDR = 2'd1,
                          WB_PC  = 2'd2;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_we;
      logic       pc_en;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_cntrl;
      logic       reg_wr;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       retire;
   } ctrl_word_t;

   // Dispatch target out of DECODE; anything not recognised lands in TRAP.
   function automatic logic [3:0] decode_target(input logic [5:0] opcode,
                                                input logic [5:0] funct);
      logic [3:0] tgt;
      tgt = S_TRAP;
      case (opcode)
         OP_LW, OP_SW: tgt = S_MEMADR;
         OP_BNE:       tgt = S_BRANCH;
         OP_XORI:      tgt = S_EXEC_I;
         OP_J, OP_JAL: tgt = S_JUMP;
         OP_R: begin
            case (funct)
               FN_ADD, FN_SUB, FN_SLT: tgt = S_EXEC_R;
               FN_JR:                  tgt = S_JUMP;
               default:                tgt = S_TRAP;
            endcase
         end
         default:      tgt = S_TRAP;
      endcase
      return tgt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_word_rom.sv
`default_nettype none
// ctrl_word_rom: combinational control word for the current state and instruction fields.
// Rev 1.0
module ctrl_word_rom
   import mips_ctrl_pkg::*;
(
   input  logic [3:0]  state,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        mem_ready,
   output ctrl_word_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_req   = 1'b1;
            ctrl.iord      = 1'b0;
            ctrl.alu_src_a = SRCA_PC;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_cntrl = ALU_ADD;
            ctrl.pc_src    = PC_SRC_PC4;
            ctrl.ir_we     = mem_ready;
            ctrl.pc_en     = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_a = SRCA_PC;
            ctrl.alu_src_b = SRCB_BOFF;
            ctrl.alu_cntrl = ALU_ADD;
         end
         S_MEMADR: begin
            ctrl.alu_src_a = SRCA_RS;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_cntrl = ALU_ADD;
         end
         S_MEMRD: begin
            ctrl.mem_req = 1'b1;
            ctrl.iord    = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_wr     = 1'b1;
            ctrl.reg_dst    = DST_RT;
            ctrl.mem_to_reg = WB_MDR;
            ctrl.retire     = 1'b1;
         end
         S_MEMWR: begin
            ctrl.mem_req = 1'b1;
            ctrl.mem_we  = 1'b1;
            ctrl.iord    = 1'b1;
            ctrl.retire  = mem_ready;
         end
         S_EXEC_R: begin
            ctrl.alu_src_a = SRCA_RS;
            ctrl.alu_src_b = SRCB_RT;
            case (funct)
               FN_SUB:  ctrl.alu_cntrl = ALU_SUB;
               FN_SLT:  ctrl.alu_cntrl = ALU_SLT;
               default: ctrl.alu_cntrl = ALU_ADD;
            endcase
         end
         S_RWB: begin
            ctrl.reg_wr     = 1'b1;
            ctrl.reg_dst    = DST_RD;
            ctrl.mem_to_reg = WB_ALU;
            ctrl.retire     = 1'b1;
         end
         S_EXEC_I: begin
            ctrl.alu_src_a = SRCA_RS;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_cntrl = ALU_XOR;
         end
         S_IWB: begin
            ctrl.reg_wr     = 1'b1;
            ctrl.reg_dst    = DST_RT;
            ctrl.mem_to_reg = WB_ALU;
            ctrl.retire     = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a = SRCA_RS;
            ctrl.alu_src_b = SRCB_RT;
            ctrl.alu_cntrl = ALU_SUB;
            ctrl.pc_src    = PC_SRC_BR;
            ctrl.pc_en     = ~zero;
            ctrl.retire    = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_en  = 1'b1;
            ctrl.retire = 1'b1;
            // JR is the only R-type that reaches JUMP.
            ctrl.pc_src = (opcode == OP_R) ? PC_SRC_RS : PC_SRC_JMP;
            if (opcode == OP_JAL) begin
               ctrl.reg_wr     = 1'b1;
               ctrl.reg_dst    = DST_RA;
               ctrl.mem_to_reg = WB_PC;
            end
         end
         default: ctrl = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// multicycle_controller: FSM, retire counter and trap flag sequencing the multicycle MIPS datapath.
// Rev 1.0
module multicycle_controller
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic             ir_we,
   output logic             pc_en,
   output logic [1:0]       pc_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [3:0]       alu_cntrl,
   output logic             reg_wr,
   output logic [1:0]       reg_dst,
   output logic [1:0]       mem_to_reg,
   output logic             illegal,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] retired
);

   ctrl_word_t ctrl;
   logic [3:0] next_state;
   logic [3:0] done_state;

   ctrl_word_rom u_rom (
      .state     (state),
      .opcode    (opcode),
      .funct     (funct),
      .zero      (zero),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   // An instruction always completes; run only decides where we go afterwards.
   assign done_state = run ? S_FETCH : S_IDLE;

   always_comb begin
      next_state = S_TRAP;
      case (state)
         S_IDLE:   next_state = run ? S_FETCH : S_IDLE;
         S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: next_state = decode_target(opcode, funct);
         S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  next_state = done_state;
         S_MEMWR:  next_state = mem_ready ? done_state : S_MEMWR;
         S_EXEC_R: next_state = S_RWB;
         S_RWB:    next_state = done_state;
         S_EXEC_I: next_state = S_IWB;
         S_IWB:    next_state = done_state;
         S_BRANCH: next_state = done_state;
         S_JUMP:   next_state = done_state;
         S_TRAP:   next_state = S_TRAP;
         default:  next_state = S_TRAP;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         retired <= '0;
         illegal <= 1'b0;
      end else begin
         state <= next_state;
         if (ctrl.retire) begin
            retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (next_state == S_TRAP) begin
            illegal <= 1'b1;
         end
      end
   end

   assign mem_req    = ctrl.mem_req;
   assign mem_we     = ctrl.mem_we;
   assign iord       = ctrl.iord;
   assign ir_we      = ctrl.ir_we;
   assign pc_en      = ctrl.pc_en;
   assign pc_src     = ctrl.pc_src;
   assign alu_src_a  = ctrl.alu_src_a;
   assign alu_src_b  = ctrl.alu_src_b;
   assign alu_cntrl  = ctrl.alu_cntrl;
   assign reg_wr     = ctrl.reg_wr;
   assign reg_dst    = ctrl.reg_dst;
   assign mem_to_reg = ctrl.mem_to_reg;

endmodule
`default_nettype wire
